// File: rtl/ntt_pkg.sv
//------------------------------------------------------------------------------
// ntt_pkg -- Shared NTT constants, coefficient types and the modular halving helper
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ntt_pkg;

  localparam int unsigned W         = 16;
  localparam int unsigned Q         = 7681;
  localparam int unsigned QHALF_INV = (Q + 1) / 2;

  // Barrett: valid for any x < 2^BARRETT_K, which covers every product of canonical operands
  localparam int unsigned BARRETT_K = 26;
  localparam int unsigned BARRETT_M = (1 << BARRETT_K) / Q;

  typedef logic [W-1:0]   coeff_t;
  typedef logic [2*W-1:0] prod_t;

  // x * 2^-1 mod Q for canonical x: an odd x is made even by adding Q first
  function automatic coeff_t halve_mod(input coeff_t x);
    logic [W:0] t;
    t = x[0] ? ({1'b0, x} + (W+1)'(Q)) : {1'b0, x};
    return t[W:1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gs_mod_reduce.sv
//------------------------------------------------------------------------------
// gs_mod_reduce -- Registered Barrett reduction of a 2W-bit product to [0,Q-1]
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gs_mod_reduce
  import ntt_pkg::*;
#(
  parameter bit HALVE = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  prod_t  x,
  output coeff_t y
);

  localparam logic [13:0] BM  = 14'(BARRETT_M);
  localparam logic [31:0] Q32 = 32'(Q);

  logic [45:0] prod;
  logic [45:0] qe;
  logic [31:0] r;
  coeff_t      red;
  coeff_t      y_next;

  assign prod = {14'b0, x} * {32'b0, BM};
  assign qe   = prod >> BARRETT_K;
  // the quotient estimate is at most one low, so a single correction suffices
  assign r    = x - 32'(qe * 46'(Q));
  assign red  = 16'((r >= Q32) ? (r - Q32) : r);

  generate
    if (HALVE) begin : g_halve
      assign y_next = halve_mod(red);
    end else begin : g_plain
      assign y_next = red;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (en) begin
      y <= y_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gs_bu_pipe.sv
//------------------------------------------------------------------------------
// gs_bu_pipe -- 3-stage Gentleman-Sande butterfly for the inverse NTT with tag passthrough
// Build option: define INTT_HALVE_EN to scale both outputs by 2^-1 mod Q
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gs_bu_pipe
  import ntt_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     zeta,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     B1,
  output logic [W-1:0]     B2,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             range_err,
  input  logic             clr_err
);

`ifdef INTT_HALVE_EN
  localparam bit HALVE = 1'b1;
`else
  localparam bit HALVE = 1'b0;
`endif

  localparam logic [W-1:0] QW = W'(Q);

  logic             adv;
  logic [W:0]       sum;
  coeff_t           s_next;
  coeff_t           d_next;
  logic             bad;
  coeff_t           b1_next;

  logic             v1, v2, v3;
  coeff_t           s1, d1, z1, s2;
  prod_t            p2;
  logic [TAG_W-1:0] t1, t2;

  assign adv       = !(v3 && !out_ready);
  assign in_ready  = adv;
  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign s_next = (sum >= (W+1)'(Q)) ? W'(sum - (W+1)'(Q)) : sum[W-1:0];
  // adding Q modulo 2^W lands the borrowed difference back in [0,Q-1]
  assign d_next = (a < b) ? (a - b + QW) : (a - b);
  assign bad    = (a >= QW) || (b >= QW) || (zeta >= QW);

  generate
    if (HALVE) begin : g_b1_halve
      assign b1_next = halve_mod(s2);
    end else begin : g_b1_plain
      assign b1_next = s2;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      s1        <= '0;
      d1        <= '0;
      z1        <= '0;
      t1        <= '0;
      s2        <= '0;
      p2        <= '0;
      t2        <= '0;
      B1        <= '0;
      out_tag   <= '0;
      range_err <= 1'b0;
    end else begin
      if (adv) begin
        v1      <= in_valid;
        s1      <= s_next;
        d1      <= d_next;
        z1      <= zeta;
        t1      <= in_tag;
        v2      <= v1;
        p2      <= prod_t'(d1) * prod_t'(z1);
        s2      <= s1;
        t2      <= t1;
        v3      <= v2;
        B1      <= b1_next;
        out_tag <= t2;
      end
      // a new out-of-range beat takes priority over a simultaneous clear
      if (in_valid && adv && bad) begin
        range_err <= 1'b1;
      end else if (clr_err) begin
        range_err <= 1'b0;
      end
    end
  end

  gs_mod_reduce #(
    .HALVE (HALVE)
  ) u_reduce (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .x   (p2),
    .y   (B2)
  );

endmodule

`default_nettype wire
